// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifft_pkg
//  Purpose  : Shared constants, FILL/DRAIN state encoding and the 4-bit
//             bit-reverse helper for the 16-point IFFT output path.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ifft_pkg;

   // Data path geometry of the 16-point, 16-bit IFFT core.
   localparam int IFFT_DATA_W   = 16;
   localparam int IFFT_N_POINTS = 16;
   localparam int IFFT_ADDR_W   = 4;

   // Reorder buffer state encoding (binary, single bit).
   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   // {b3,b2,b1,b0} -> {b0,b1,b2,b3}
   function automatic logic [3:0] bitrev4(input logic [3:0] a);
      return {a[0], a[1], a[2], a[3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifft_addr_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ifft_addr_mux
//  Purpose  : Two-way address select shared by the IFFT memories.
//             sel=0 passes addr0, sel=1 passes addr1.
//  Ports    : sel   - select (input)
//             addr0 - address used when sel=0 (input)
//             addr1 - address used when sel=1 (input)
//             addr  - selected address (output)
//  Revision : 1.0 - initial release
// ============================================================================
module ifft_addr_mux #(
   parameter int ADDR_W = 4
) (
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic [ADDR_W-1:0] addr
);

   assign addr = sel ? addr1 : addr0;

endmodule
`default_nettype wire

// File: rtl/ifft_bitrev4.sv
`default_nettype none
// ============================================================================
//  Module   : ifft_bitrev4
//  Purpose  : Combinational 4-bit bit-reverse used to form the write address
//             of the IFFT reorder buffer.
//  Ports    : a - natural 4-bit index (input)
//             y - bit-reversed index (output)
//  Revision : 1.0 - initial release
// ============================================================================
module ifft_bitrev4
   import ifft_pkg::*;
(
   input  logic [3:0] a,
   output logic [3:0] y
);

   assign y = bitrev4(a);

endmodule
`default_nettype wire

// File: rtl/ifft_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ifft_reorder_buf
//  Purpose  : Output reorder buffer for the 16-point IFFT. A frame arriving
//             in butterfly order is written at bit-reversed addresses and
//             then streamed out in natural order 0..15. One 16-entry bank,
//             so fill and drain alternate.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             in_valid  - input sample present
//             in_ready  - buffer accepts a sample (high in FILL)
//             in_re/im  - input sample components
//             out_valid - output sample present (high in DRAIN)
//             out_ready - downstream accepts the sample
//             out_re/im - output sample components (0 when not valid)
//             out_last  - marks sample index 15
//             busy      - high while draining
//  Revision : 1.0 - initial release
// ============================================================================
module ifft_reorder_buf
   import ifft_pkg::*;
#(
   parameter int DATA_W   = IFFT_DATA_W,
   parameter int N_POINTS = IFFT_N_POINTS,
   parameter int ADDR_W   = IFFT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic              out_last,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

   logic [0:0]          state;
   logic [ADDR_W-1:0]   wr_cnt;
   logic [ADDR_W-1:0]   rd_cnt;
   logic [ADDR_W-1:0]   wr_addr;
   logic [ADDR_W-1:0]   mem_addr;
   logic                in_fire;
   logic                out_fire;
   logic                draining;
   logic [2*DATA_W-1:0] rd_word;

   // Sample storage; contents are not reset (a frame always rewrites all
   // 16 entries before it is read).
   logic [2*DATA_W-1:0] mem [N_POINTS];

   assign draining  = (state == ST_DRAIN);
   assign in_ready  = !draining;
   assign out_valid = draining;
   assign busy      = draining;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   ifft_bitrev4 u_bitrev (
      .a (wr_cnt),
      .y (wr_addr)
   );

   // One address port: bit-reversed write address while filling,
   // natural read address while draining.
   ifft_addr_mux #(
      .ADDR_W (ADDR_W)
   ) u_addr_mux (
      .sel   (draining),
      .addr0 (wr_addr),
      .addr1 (rd_cnt),
      .addr  (mem_addr)
   );

   // Control: state and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_FILL;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (in_fire) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_IDX) begin
                     state  <= ST_DRAIN;
                     rd_cnt <= '0;
                  end
               end
            end
            default: begin
               if (out_fire) begin
                  rd_cnt <= rd_cnt + 1'b1;
                  if (rd_cnt == LAST_IDX) begin
                     state <= ST_FILL;
                  end
               end
            end
         endcase
      end
   end

   // Memory write; in_fire implies FILL, so mem_addr is the write address.
   always_ff @(posedge clk) begin
      if (!rst && in_fire) begin
         mem[mem_addr] <= {in_re, in_im};
      end
   end

   // Read straight from the register array, no pipeline stage.
   assign rd_word = mem[mem_addr];

   always_comb begin
      out_re   = '0;
      out_im   = '0;
      out_last = 1'b0;
      if (out_valid) begin
         out_re   = rd_word[2*DATA_W-1:DATA_W];
         out_im   = rd_word[DATA_W-1:0];
         out_last = (rd_cnt == LAST_IDX);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifft_reorder_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifft_reorder_buf
//  Purpose  : Self-checking bench for ifft_reorder_buf. Each driven frame
//             pushes its expected natural-order output into a queue which
//             the drain loops pop and compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifft_reorder_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_re;
   logic [15:0] in_im;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_re;
   logic [15:0] out_im;
   logic        out_last;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [15:0] fre [16];
   logic [15:0] fim [16];
   logic [31:0] exp_q [$];
   logic        saw_valid;

   ifft_reorder_buf dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [3:0] rev(input logic [3:0] v);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = v[3-i];
      return r;
   endfunction

   // Advance one clock; inputs are changed and outputs sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive fre/fim as one frame (with optional random input gaps) and queue
   // the natural-order output the frame should produce.
   task automatic push_frame(input int gap_pct);
      int k = 0;
      int guard = 0;
      logic acc;
      saw_valid = 1'b0;
      while (k < 16 && guard < 400) begin
         if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_re    = 16'hDEAD;
            in_im    = 16'hBEEF;
         end else begin
            in_valid = 1'b1;
            in_re    = fre[k];
            in_im    = fim[k];
         end
         if (out_valid) saw_valid = 1'b1;
         acc = in_valid && in_ready;
         step();
         guard++;
         if (acc) k++;
      end
      in_valid = 1'b0;
      if (k < 16) begin
         checks++;
         failures++;
         $display("FAIL fill_timeout accepted=%0d required=16", k);
      end
      for (int j = 0; j < 16; j++) exp_q.push_back({fre[rev(4'(j))], fim[rev(4'(j))]});
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
      step(); step();
      checks++;
      if ({in_ready, out_valid, out_last, busy, out_re, out_im} !== {4'b1000, 32'h0}) begin
         failures++;
         $display("FAIL reset_state got rdy=%b vld=%b last=%b busy=%b re=%h im=%h required rdy=1 others 0",
                  in_ready, out_valid, out_last, busy, out_re, out_im);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_ramp();
      int n = 0;
      int guard = 0;
      for (int k = 0; k < 16; k++) begin fre[k] = 16'(k); fim[k] = 16'(-k); end
      out_ready = 1'b1;
      push_frame(0);
      checks++;
      if (saw_valid !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL ramp_valid_rise got early=%b now=%b required early=0 now=1", saw_valid, out_valid);
      end
      while (n < 16 && guard < 100) begin
         if (out_valid && out_ready) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({out_re, out_im, out_last} !== {e, (n == 15)}) begin
               failures++;
               $display("FAIL ramp_data idx=%0d got %h/%h last=%b required %h/%h last=%b",
                        n, out_re, out_im, out_last, e[31:16], e[15:0], (n == 15));
            end
            n++;
         end
         step();
         guard++;
      end
      checks++;
      if (n != 16 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ramp_end got n=%0d rdy=%b busy=%b required 16/1/0", n, in_ready, busy);
      end
   endtask

   task automatic test_gaps_backpressure();
      int n = 0;
      int guard = 0;
      logic stalled = 1'b0;
      logic [31:0] held;
      for (int k = 0; k < 16; k++) begin fre[k] = 16'($urandom); fim[k] = 16'($urandom); end
      out_ready = 1'b0;
      push_frame(40);
      while (n < 16 && guard < 300) begin
         if (stalled) begin
            checks++;
            if ({out_valid, out_re, out_im} !== {1'b1, held}) begin
               failures++;
               $display("FAIL stall_hold got vld=%b %h/%h required vld=1 %h/%h",
                        out_valid, out_re, out_im, held[31:16], held[15:0]);
            end
         end
         out_ready = $urandom_range(1);
         stalled = out_valid && !out_ready;
         held = {out_re, out_im};
         if (out_valid && out_ready) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({out_re, out_im, out_last} !== {e, (n == 15)}) begin
               failures++;
               $display("FAIL gap_data idx=%0d got %h/%h last=%b required %h/%h last=%b",
                        n, out_re, out_im, out_last, e[31:16], e[15:0], (n == 15));
            end
            n++;
         end
         step();
         guard++;
      end
      checks++;
      if (n != 16 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL gap_count got n=%0d left=%0d required 16/0", n, exp_q.size());
      end
   endtask

   task automatic test_drain_input();
      int n = 0;
      int guard = 0;
      int bad_rdy = 0;
      for (int k = 0; k < 16; k++) begin fre[k] = 16'(16'h1000 + k * 3); fim[k] = 16'(16'hA000 - k * 7); end
      out_ready = 1'b1;
      push_frame(0);
      while (n < 16 && guard < 100) begin
         in_valid = 1'b1;
         in_re = 16'($urandom);
         in_im = 16'($urandom);
         if (in_ready !== 1'b0) bad_rdy++;
         if (out_valid && out_ready) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({out_re, out_im} !== e) begin
               failures++;
               $display("FAIL drain_input_data idx=%0d got %h/%h required %h/%h",
                        n, out_re, out_im, e[31:16], e[15:0]);
            end
            n++;
         end
         step();
         guard++;
      end
      in_valid = 1'b0;
      checks++;
      if (bad_rdy != 0) begin
         failures++;
         $display("FAIL drain_in_ready got %0d cycles with in_ready!=0 required 0", bad_rdy);
      end
      checks++;
      if (n != 16 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL drain_to_fill got n=%0d rdy=%b required 16/1", n, in_ready);
      end
   endtask

   task automatic test_reset_mid_drain();
      int n = 0;
      int guard = 0;
      for (int k = 0; k < 16; k++) begin fre[k] = 16'(k); fim[k] = 16'(-k); end
      out_ready = 1'b1;
      push_frame(0);
      while (n < 5 && guard < 50) begin
         if (out_valid) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({out_re, out_im} !== e) begin
               failures++;
               $display("FAIL mid_drain_pre idx=%0d got %h/%h required %h/%h",
                        n, out_re, out_im, e[31:16], e[15:0]);
            end
            n++;
         end
         step();
         guard++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({out_valid, out_re, out_im, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
         failures++;
         $display("FAIL mid_drain_reset got vld=%b re=%h im=%h rdy=%b required 0/0/0/1",
                  out_valid, out_re, out_im, in_ready);
      end
      exp_q.delete();
      test_ramp();
   endtask

   task automatic test_reset_mid_fill();
      int n = 0;
      int guard = 0;
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1; in_re = 16'(16'h0100 + k); in_im = 16'(16'h0200 + k);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         logic [3:0] kb;
         kb = 4'(k);
         fre[k] = kb[0] ? 16'h8000 : 16'h7FFF;
         fim[k] = kb[1] ^ kb[3] ? 16'h7FFF : 16'h8000;
      end
      out_ready = 1'b1;
      push_frame(0);
      while (n < 16 && guard < 100) begin
         if (out_valid) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({out_re, out_im, out_last} !== {e, (n == 15)}) begin
               failures++;
               $display("FAIL extreme_data idx=%0d got %h/%h last=%b required %h/%h last=%b",
                        n, out_re, out_im, out_last, e[31:16], e[15:0], (n == 15));
            end
            n++;
         end
         step();
         guard++;
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         int n = 0;
         int guard = 0;
         int t0;
         for (int k = 0; k < 16; k++) begin fre[k] = 16'(f * 256 + k); fim[k] = 16'(16'hF000 + f * 16 + k); end
         out_ready = 1'b1;
         t0 = cyc;
         push_frame(0);
         while (n < 16 && guard < 100) begin
            in_valid = 1'b1;
            in_re = 16'hFFFF;
            in_im = 16'hFFFF;
            if (out_valid) begin
               logic [31:0] e;
               e = exp_q.pop_front();
               checks++;
               if ({out_re, out_im, out_last} !== {e, (n == 15)}) begin
                  failures++;
                  $display("FAIL b2b_data frame=%0d idx=%0d got %h/%h required %h/%h",
                           f, n, out_re, out_im, e[31:16], e[15:0]);
               end
               n++;
            end
            step();
            guard++;
         end
         in_valid = 1'b0;
         checks++;
         if (cyc - t0 != 32 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_period frame=%0d got %0d cycles rdy=%b required 32 cycles rdy=1",
                     f, cyc - t0, in_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_gaps_backpressure();
      test_drain_input();
      test_reset_mid_drain();
      test_reset_mid_fill();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
